// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the async FIFO.
// Gray helpers work on a wide vector; callers cast to pointer width.
package fifo_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int PMAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic [PMAX-1:0] bin2gray(
    input logic [PMAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PMAX-1:0] gray2bin(
    input logic [PMAX-1:0] g
  );
    logic [PMAX-1:0] b;
    b[PMAX-1] = g[PMAX-1];
    for (int i = PMAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle: synced write pointer, RAM read port,
// FWFT output stream and exported Gray read pointer.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DWIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_sync;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic [AW:0]       rptr_gray;
  logic [DWIDTH-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              mem_empty;
  logic [AW:0]       fill_level;

  modport master (
    input  wptr_sync, rd_data, dout_ready,
    output rd_en, rd_addr, rptr_gray,
    output dout, dout_valid, mem_empty,
    output fill_level
  );

  modport slave (
    output wptr_sync, rd_data, dout_ready,
    input  rd_en, rd_addr, rptr_gray,
    input  dout, dout_valid, mem_empty,
    input  fill_level
  );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry FWFT skid buffer: head drives dout, skid
// catches a word that lands while the head is still held.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  output logic [1:0]        count
);

  buf_state_t        state;
  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] skid;

  assign dout       = head;
  assign dout_valid = (state != EMPTY);
  assign count      = state;

  // Occupancy FSM; oldest word always sits in head.
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_valid) begin
            head  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_valid && !pop) begin
            skid  <= in_data;
            state <= TWO;
          end else if (in_valid && pop) begin
            head <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head <= skid;
            if (in_valid) skid <= in_data;
            else state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: owns the read
// pointer, issues RAM reads and feeds the FWFT buffer.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DWIDTH = 8
) (
  input logic            clk_out,
  input logic            rst_n,
  fifo_rd_ctrl_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] rptr_gray;
  logic [PW-1:0] rptr_nxt;
  logic [PW-1:0] wptr_bin;
  logic          inflight;
  logic          mem_empty;
  logic          rd_en;
  logic          pop;
  logic          dout_valid;
  logic [1:0]    count;
  logic [2:0]    occ;

  assign rptr_nxt = rptr_bin + PW'(1);
  assign wptr_bin =
    PW'(gray2bin(PMAX'(bus.wptr_sync)));

  // Held empty during reset so no read fires then.
  assign mem_empty =
    !rst_n || (rptr_gray == bus.wptr_sync);

  assign pop = dout_valid & bus.dout_ready;
  assign occ = {1'b0, count}
             + {2'b0, inflight}
             - {2'b0, pop};
  assign rd_en = !mem_empty && (occ < 3'd2);

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rptr_bin[AW-1:0];
  assign bus.rptr_gray  = rptr_gray;
  assign bus.mem_empty  = mem_empty;
  assign bus.fill_level = wptr_bin - rptr_bin;
  assign bus.dout_valid = dout_valid;

  // Advance both pointer encodings together; track the
  // word in flight from the RAM.
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        rptr_bin  <= rptr_nxt;
        rptr_gray <= PW'(bin2gray(PMAX'(rptr_nxt)));
      end
    end
  end

  fifo_out_buf #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .in_valid  (inflight),
    .in_data   (bus.rd_data),
    .pop       (pop),
    .dout      (bus.dout),
    .dout_valid(dout_valid),
    .count     (count)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a small RAM model
// answering rd_en one cycle later.
module tb_fifo_rd_ctrl;

  localparam int DEPTH  = 8;
  localparam int DWIDTH = 8;

  logic clk_out = 1'b0;
  logic rst_n   = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;
  logic [7:0] mem [8];

  fifo_rd_ctrl_if #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) bus ();

  fifo_rd_ctrl #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) dut (
    .clk_out(clk_out),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_out = ~clk_out;

  always @(posedge clk_out) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic next_cycle();
    @(posedge clk_out);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.wptr_sync = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk_out);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wptr_sync = 4'b0110;
    bus.dout_ready = 1'b1;
    repeat (2) @(posedge clk_out);
    #1;
    n_vec++;
    if (bus.rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rd_en got %b want 0", bus.rd_en);
    end
    n_vec++;
    if (bus.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid got %b want 0",
               bus.dout_valid);
    end
    n_vec++;
    if (bus.rptr_gray !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_rptr got %b want 0000",
               bus.rptr_gray);
    end
    n_vec++;
    if (bus.mem_empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_empty got %b want 1",
               bus.mem_empty);
    end
    n_vec++;
    if (bus.dout !== 8'h00) begin
      n_err++;
      $display("FAIL reset_dout got %h want 00", bus.dout);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.wptr_sync = 4'b0001;
    bus.dout_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL single_rd_en got %b want 1", bus.rd_en);
    end
    n_vec++;
    if (bus.rd_addr !== 3'd0) begin
      n_err++;
      $display("FAIL single_addr got %0d want 0",
               bus.rd_addr);
    end
    next_cycle();
    n_vec++;
    if (bus.rptr_gray !== 4'b0001) begin
      n_err++;
      $display("FAIL single_rptr got %b want 0001",
               bus.rptr_gray);
    end
    n_vec++;
    if (bus.mem_empty !== 1'b1 || bus.rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_empty got %b/%b want 1/0",
               bus.mem_empty, bus.rd_en);
    end
    next_cycle();
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== mem[0]) begin
      n_err++;
      $display("FAIL single_dout got %b/%h want 1/%h",
               bus.dout_valid, bus.dout, mem[0]);
    end
    next_cycle();
    n_vec++;
    if (bus.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain got %b want 0",
               bus.dout_valid);
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    int got;
    do_reset();
    bus.wptr_sync = 4'b1100;
    bus.dout_ready = 1'b0;
    #1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      if (bus.rd_en === 1'b1) pulses++;
      if (c >= 2) begin
        n_vec++;
        if (bus.dout_valid !== 1'b1 ||
            bus.dout !== mem[0]) begin
          n_err++;
          $display("FAIL bp_hold c%0d got %b/%h want 1/%h",
                   c, bus.dout_valid, bus.dout, mem[0]);
        end
      end
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL bp_pulses got %0d want 2", pulses);
    end
    n_vec++;
    if (bus.fill_level !== 4'd6) begin
      n_err++;
      $display("FAIL bp_fill got %0d want 6",
               bus.fill_level);
    end
    bus.dout_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      if (bus.dout_valid === 1'b1) begin
        n_vec++;
        if (bus.dout !== mem[got]) begin
          n_err++;
          $display("FAIL bp_order w%0d got %h want %h",
                   got, bus.dout, mem[got]);
        end
        got++;
      end
      next_cycle();
    end
    n_vec++;
    if (got != 8) begin
      n_err++;
      $display("FAIL bp_count got %0d want 8", got);
    end
    n_vec++;
    if (bus.dout_valid !== 1'b0 || bus.mem_empty !== 1'b1) begin
      n_err++;
      $display("FAIL bp_end got %b/%b want 0/1",
               bus.dout_valid, bus.mem_empty);
    end
  endtask

  task automatic test_stream();
    logic exp_en;
    do_reset();
    bus.wptr_sync = 4'b1100;
    bus.dout_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      exp_en = (c < 8);
      n_vec++;
      if (bus.rd_en !== exp_en) begin
        n_err++;
        $display("FAIL stream_en c%0d got %b want %b",
                 c, bus.rd_en, exp_en);
      end
      n_vec++;
      if (c >= 2 && c <= 9) begin
        if (bus.dout_valid !== 1'b1 ||
            bus.dout !== mem[c-2]) begin
          n_err++;
          $display("FAIL stream_dout c%0d got %b/%h want 1/%h",
                   c, bus.dout_valid, bus.dout, mem[c-2]);
        end
      end else if (bus.dout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stream_idle c%0d got %b want 0",
                 c, bus.dout_valid);
      end
    end
    n_vec++;
    if (bus.rptr_gray !== 4'b1100) begin
      n_err++;
      $display("FAIL stream_rptr got %b want 1100",
               bus.rptr_gray);
    end
  endtask

  task automatic test_wrap();
    mem[0] = 8'h3C;
    next_cycle();
    bus.wptr_sync = 4'b1101;
    #1;
    n_vec++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== 3'd0) begin
      n_err++;
      $display("FAIL wrap_issue got %b/%0d want 1/0",
               bus.rd_en, bus.rd_addr);
    end
    next_cycle();
    n_vec++;
    if (bus.rptr_gray !== 4'b1101 || bus.rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_rptr got %b/%b want 1101/0",
               bus.rptr_gray, bus.rd_en);
    end
    next_cycle();
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h3C) begin
      n_err++;
      $display("FAIL wrap_dout got %b/%h want 1/3c",
               bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    bus.wptr_sync = 4'b1100;
    bus.dout_ready = 1'b0;
    #1;
    next_cycle();
    next_cycle();
    n_vec++;
    if (bus.dout_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre got %b want 1", bus.dout_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rd_en got %b want 0", bus.rd_en);
    end
    next_cycle();
    n_vec++;
    if (bus.dout_valid !== 1'b0 ||
        bus.rptr_gray !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset got %b/%b want 0/0000",
               bus.dout_valid, bus.rptr_gray);
    end
    rst_n = 1'b1;
    bus.wptr_sync = '0;
    #1;
    next_cycle();
    n_vec++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h00) begin
      n_err++;
      $display("FAIL mid_after got %b/%h want 0/00",
               bus.dout_valid, bus.dout);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'hA0 + i);
    bus.rd_data = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_wrap();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
